pipe_stage_elastic: RTL and testbench

- Generic, parametrised inter-stage pipeline register; successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NLANES data words of DATA_W bits plus a CTRL_W control bundle.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, debug step gating, flush, and forced-bubble control outputs.
- Sits between any two pipeline stages; the hazard unit drives i_flush, the debug unit drives i_step.

---
 rtl/pipe_stage_elastic_pkg.sv | 8 +
 rtl/pipe_stage_elastic_if.sv | 13 +
 rtl/pipe_stage_elastic_slot.sv | 24 ++
 rtl/pipe_stage_elastic.sv | 84 ++++++++
 tb/tb_pipe_stage_elastic.sv | 114 +++++++++++
 5 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: shared state type, bubble control constant and occupancy mapping for the elastic stage.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t;
  localparam logic CTRL_BUBBLE = 1'b0;
  function automatic logic [1:0] occ_of(pipe_state_t s);
    return (s == SKID) ? 2'd2 : (s == FULL) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: valid/ready handshake bus carrying data lanes and a control bundle.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 32,
  parameter int NLANES = 5,
  parameter int CTRL_W = 16
);
  logic                     valid;
  logic                     ready;
  logic [NLANES*DATA_W-1:0] data;
  logic [CTRL_W-1:0]        ctrl;
  modport master(output valid, data, ctrl, input ready);
  modport slave(input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_elastic_slot.sv
// pipe_slot: one storage entry (valid + word) with load and synchronous clear; clear wins over load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);
  logic         v_q, v_d;
  logic [W-1:0] w_q, w_d;
  always_comb begin
    v_d = clr ? 1'b0 : ld ? 1'b1 : v_q;
    w_d = clr ? '0 : ld ? d : w_q;
  end
  always_ff @(posedge clk) begin
    v_q <= v_d;
    w_q <= w_d;
  end
  assign v = v_q;
  assign q = w_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with step gating and flush; PIPE_SKID_BUFFER_EN adds a 2-entry skid buffer.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NLANES = 5,
  parameter int CTRL_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_step,
  pipe_stage_elastic_if.slave   up,
  pipe_stage_elastic_if.master  dn,
  output logic [1:0]            o_occ
);
  localparam int W = NLANES*DATA_W + CTRL_W;
  pipe_state_t  state_q, state_d;
  logic [W-1:0] in_w, main_w, main_in;
  logic         main_v, main_ld, main_clr, acc, pop, kill;
  assign kill = i_reset | i_flush;
  assign in_w = {up.data, up.ctrl};
  assign acc  = up.valid & up.ready;
  assign pop  = main_v & dn.ready & i_step;
  pipe_slot #(.W(W)) u_main (.clk(i_clk), .clr(main_clr), .ld(main_ld), .d(main_in), .v(main_v), .q(main_w));
`ifdef PIPE_SKID_BUFFER_EN
  logic [W-1:0] skid_w;
  logic         skid_v, skid_ld, skid_clr;
  pipe_slot #(.W(W)) u_skid (.clk(i_clk), .clr(skid_clr), .ld(skid_ld), .d(in_w), .v(skid_v), .q(skid_w));
  // ready comes from registered state only, so i_ready never reaches upstream
  assign up.ready = ~i_reset & i_step & (state_q != SKID);
  assign main_in  = skid_v ? skid_w : in_w;
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = kill;
    skid_ld  = 1'b0;
    skid_clr = kill;
    case (state_q)
      EMPTY: begin
        state_d = acc ? FULL : EMPTY;
        main_ld = acc;
      end
      FULL: begin
        state_d  = (acc & ~pop) ? SKID : (pop & ~acc) ? EMPTY : FULL;
        main_ld  = acc & pop;
        main_clr = kill | (pop & ~acc);
        skid_ld  = acc & ~pop;
      end
      SKID: begin
        state_d  = pop ? FULL : SKID;
        main_ld  = pop;
        skid_clr = kill | pop;
      end
      default: state_d = EMPTY;
    endcase
    if (kill) state_d = EMPTY;
  end
`else
  assign up.ready = ~i_reset & i_step & (~main_v | dn.ready);
  assign main_in  = in_w;
  always_comb begin
    state_d  = state_q;
    main_ld  = acc;
    main_clr = kill;
    case (state_q)
      EMPTY: state_d = acc ? FULL : EMPTY;
      FULL: begin
        state_d  = (pop & ~acc) ? EMPTY : FULL;
        main_clr = kill | (pop & ~acc);
      end
      default: state_d = EMPTY;
    endcase
    if (kill) state_d = EMPTY;
  end
`endif
  always_ff @(posedge i_clk) begin
    state_q <= i_reset ? EMPTY : state_d;
  end
  assign dn.valid = main_v;
  assign dn.data  = main_w[W-1:CTRL_W];
  assign dn.ctrl  = main_v ? main_w[CTRL_W-1:0] : {CTRL_W{CTRL_BUBBLE}};
  assign o_occ    = occ_of(state_q);
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed plus random checks of the elastic stage against a FIFO-style reference model.
module tb_pipe_stage_elastic;
  localparam int DW = 32, NL = 5, CW = 16, BW = DW*NL;
  typedef struct packed {
    logic [BW-1:0] d;
    logic [CW-1:0] c;
  } word_t;
  logic       i_clk = 1'b0;
  logic       i_reset, i_flush, i_step;
  logic [1:0] o_occ;
  word_t      q[$];
  bit         zero_data = 1'b1;
  int         ncmp = 0, nerr = 0;
  pipe_stage_elastic_if #(.DATA_W(DW), .NLANES(NL), .CTRL_W(CW)) up ();
  pipe_stage_elastic_if #(.DATA_W(DW), .NLANES(NL), .CTRL_W(CW)) dn ();
  pipe_stage_elastic #(.DATA_W(DW), .NLANES(NL), .CTRL_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_step(i_step),
    .up(up.slave), .dn(dn.master), .o_occ(o_occ)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [BW-1:0] lanes(input logic [DW-1:0] base);
    logic [BW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*DW +: DW] = base + DW'(k);
    return r;
  endfunction
  function automatic logic [BW-1:0] rnd_lanes();
    logic [BW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction
  // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic cyc(input logic rst, input logic fl, input logic st, input logic v, input logic rdy,
                     input logic [BW-1:0] d, input logic [CW-1:0] c, input string tag);
    logic          er, acc, pop;
    logic [BW-1:0] ed;
    logic [CW-1:0] ec;
    i_reset = rst; i_flush = fl; i_step = st;
    up.valid = v; up.data = d; up.ctrl = c; dn.ready = rdy;
    #1;
`ifdef PIPE_SKID_BUFFER_EN
    er = !rst && st && (q.size() < 2);
`else
    er = !rst && st && (q.size() == 0 || rdy);
`endif
    ec = (q.size() > 0) ? q[0].c : '0;
    ed = (q.size() > 0) ? q[0].d : '0;
    ncmp++;
    assert (dn.valid === (q.size() > 0)) else begin nerr++; $error("FAIL %s o_valid obs=%0b exp=%0b", tag, dn.valid, q.size() > 0); end
    ncmp++;
    assert (o_occ === 2'(q.size())) else begin nerr++; $error("FAIL %s o_occ obs=%0d exp=%0d", tag, o_occ, q.size()); end
    ncmp++;
    assert (up.ready === er) else begin nerr++; $error("FAIL %s o_ready obs=%0b exp=%0b", tag, up.ready, er); end
    ncmp++;
    assert (dn.ctrl === ec) else begin nerr++; $error("FAIL %s o_ctrl obs=%0h exp=%0h", tag, dn.ctrl, ec); end
    if (q.size() > 0 || zero_data) begin
      ncmp++;
      assert (dn.data === ed) else begin nerr++; $error("FAIL %s o_data obs=%0h exp=%0h", tag, dn.data, ed); end
    end
    acc = v && er;
    pop = (q.size() > 0) && rdy && st;
    @(posedge i_clk);
    if (rst || fl) begin
      q.delete();
      zero_data = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back('{d: d, c: c});
        zero_data = 1'b0;
      end
    end
    @(negedge i_clk);
  endtask
  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_step = 1'b0;
    up.valid = 1'b0; up.data = '0; up.ctrl = '0; dn.ready = 1'b0;
    @(negedge i_clk);
    cyc(1, 0, 0, 0, 0, '0, '0, "reset0");
    cyc(1, 0, 1, 1, 1, lanes(32'h99), 16'h7, "reset_step");
    cyc(0, 0, 1, 1, 1, lanes(32'h11), 16'h0003, "basic_push");
    cyc(0, 0, 1, 0, 1, '0, '0, "basic_out");
    cyc(0, 0, 1, 0, 1, '0, '0, "basic_empty");
    cyc(0, 0, 1, 1, 0, lanes(32'hA0), 16'h00A0, "bp_push_a");
    cyc(0, 0, 1, 1, 0, lanes(32'hB0), 16'h00B0, "bp_push_b");
    cyc(0, 0, 1, 1, 0, lanes(32'hC0), 16'h00C0, "bp_full");
    cyc(0, 0, 1, 0, 1, '0, '0, "bp_drain1");
    cyc(0, 0, 1, 0, 1, '0, '0, "bp_drain2");
    cyc(0, 0, 1, 0, 1, '0, '0, "bp_drain3");
    cyc(0, 0, 1, 1, 0, lanes(32'h20), 16'h0020, "frz_fill1");
    cyc(0, 0, 1, 1, 0, lanes(32'h30), 16'h0030, "frz_fill2");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, lanes(32'h40), 16'h0040, "freeze");
    cyc(0, 0, 1, 0, 1, '0, '0, "frz_drain1");
    cyc(0, 0, 1, 0, 1, '0, '0, "frz_drain2");
    cyc(0, 0, 1, 1, 0, lanes(32'h50), 16'h0050, "fl_fill1");
    cyc(0, 0, 1, 1, 0, lanes(32'h60), 16'h0060, "fl_fill2");
    cyc(0, 1, 1, 1, 0, lanes(32'h70), 16'h0070, "flush");
    cyc(0, 0, 1, 0, 1, '0, 16'hFFFF, "bubble1");
    cyc(0, 0, 1, 0, 1, '0, 16'hFFFF, "bubble2");
    cyc(0, 0, 1, 1, 1, lanes(32'h80), 16'h0081, "tog_1");
    cyc(0, 0, 1, 1, 0, lanes(32'h90), 16'h0091, "tog_0");
    cyc(0, 0, 1, 1, 1, lanes(32'hA8), 16'h00A8, "tog_1b");
    cyc(0, 0, 1, 1, 0, lanes(32'hB8), 16'h00B8, "tog_0b");
    cyc(0, 0, 1, 1, 1, lanes(32'hC8), 16'h00C8, "tog_1c");
    cyc(0, 0, 1, 1, 1, lanes(32'hD8), 16'h00D8, "tog_1d");
    cyc(0, 0, 0, 0, 1, '0, '0, "flush_nostep_pre");
    cyc(0, 1, 0, 1, 1, lanes(32'hE8), 16'h00E8, "flush_nostep");
    cyc(0, 0, 1, 0, 0, '0, '0, "after_flush");
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(99) == 0), ($urandom_range(49) == 0), ($urandom_range(9) < 8),
          ($urandom_range(9) < 7), ($urandom_range(9) < 6), rnd_lanes(), CW'($urandom), "random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
